// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift one command
// byte with odd parity, sample the device ACK, and report done or timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  // A byte transfers on any clk edge where cmd_valid && cmd_ready; cmd_data
  // must be stable in that cycle. cmd_valid offered while busy is ignored.
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       done,
  output logic       ack_ok,
  output logic       timeout,
  output logic [2:0] state_dbg
);

  localparam int PH_MAX  = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int CNT_MAX = (PH_MAX > TIMEOUT_CYCLES) ? PH_MAX : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_START     = 3'd2,
    S_SHIFT     = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  edge_q, edge_d;
  logic [7:0]  data_q, data_d;
  logic        parity_q, parity_d;
  logic        clk_oe_q, clk_oe_d;
  logic        dat_oe_q, dat_oe_d;
  logic        done_q, done_d;
  logic        ack_q, ack_d;
  logic        timeout_q, timeout_d;
  logic [1:0]  clk_s_q, dat_s_q;
  logic        clk_prev_q;

  logic clk_sync, dat_sync, fall, accept, expired;

  assign clk_sync = clk_s_q[1];
  assign dat_sync = dat_s_q[1];
  assign fall     = clk_prev_q & ~clk_sync;
  // Hold off ready during the done/timeout pulse so it returns the cycle after.
  assign cmd_ready = (state_q == S_IDLE) && !done_q && !timeout_q;
  assign busy      = (state_q != S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign expired   = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign done       = done_q;
  assign ack_ok     = ack_q;
  assign timeout    = timeout_q;
  assign state_dbg  = state_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    data_d    = data_q;
    parity_d  = parity_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    ack_d     = ack_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (accept) begin
          data_d   = cmd_data;
          parity_d = ~^cmd_data;
          edge_d   = 4'd0;
          cnt_d    = '0;
          ack_d    = 1'b0;
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          cnt_d    = '0;
          dat_oe_d = 1'b1;
          state_d  = S_START;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_START: begin
        if (cnt_q == CW'(START_CYCLES - 1)) begin
          cnt_d    = '0;
          clk_oe_d = 1'b0;
          state_d  = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHIFT, S_WAIT_IDLE: begin
        // Timeout wins over an edge or the idle condition in the same cycle.
        if (expired) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          ack_d     = 1'b0;
          clk_oe_d  = 1'b0;
          dat_oe_d  = 1'b0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (state_q == S_WAIT_IDLE) begin
            if (clk_sync && dat_sync) begin
              cnt_d   = '0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else if (fall) begin
            edge_d = edge_q + 4'd1;
            if (edge_q < 4'd8) begin
              dat_oe_d = ~data_q[edge_q[2:0]];
            end else if (edge_q == 4'd8) begin
              dat_oe_d = ~parity_q;
            end else if (edge_q == 4'd9) begin
              dat_oe_d = 1'b0;
            end else begin
              ack_d   = ~dat_sync;
              state_d = S_WAIT_IDLE;
            end
          end
        end
      end
      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      edge_q     <= 4'd0;
      data_q     <= 8'd0;
      parity_q   <= 1'b0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
      timeout_q  <= 1'b0;
      clk_s_q    <= 2'b11;
      dat_s_q    <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      data_q     <= data_d;
      parity_q   <= parity_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
      timeout_q  <= timeout_d;
      clk_s_q    <= {clk_s_q[0], ps2_clk_in};
      dat_s_q    <= {dat_s_q[0], ps2_dat_in};
      clk_prev_q <= clk_sync;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain pin model plus a PS/2 device model that
// clocks the frame, samples bits on rising edges and optionally ACKs.
module tb_ps2_host_tx;

  localparam int INH = 5000;
  localparam int STR = 50;
  localparam int TO  = 3000;
  localparam int H   = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, busy, ps2_clk_oe, ps2_dat_oe, done, ack_ok, timeout;
  logic [2:0] state_dbg;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk_in, ps2_dat_in;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rel_cyc = 0;
  logic [9:0] exp_q[$];
  logic [1:0] end_q[$];

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_CYCLES(STR),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_data(cmd_data),
    .cmd_ready(cmd_ready),
    .busy(busy),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .done(done),
    .ack_ok(ack_ok),
    .timeout(timeout),
    .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

  // Accept a byte and measure the inhibit and request-to-send phases.
  task automatic send(input logic [7:0] b, input bit poke);
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b1;
    cmd_data  = b;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("accept_clk_oe", ps2_clk_oe, 1);
    chk("accept_busy", busy, 1);
    n = 0;
    while (ps2_clk_oe && !ps2_dat_oe && n < INH + 20) begin
      n++;
      @(negedge clk);
      if (poke && n == 10) begin
        cmd_valid = 1'b1;
        cmd_data  = ~b;
      end
      if (poke && n == 12) chk("ready_low_while_busy", cmd_ready, 0);
      if (poke && n == 14) cmd_valid = 1'b0;
    end
    chk("inhibit_len", n, INH);
    n = 0;
    while (ps2_clk_oe && ps2_dat_oe && n < STR + 20) begin
      n++;
      @(negedge clk);
    end
    chk("start_len", n, STR);
    rel_cyc = cyc;
    chk("start_bit_held", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
  endtask

  // Device: n_edges clock pulses; samples host data on each rising edge.
  task automatic dev_frame(input int n_edges, input bit do_ack, output logic [9:0] bits);
    bits = '0;
    for (int i = 1; i <= n_edges; i++) begin
      if (i == 11 && do_ack) dev_dat_low = 1'b1;
      wait_cycles(H);
      dev_clk_low = 1'b1;
      wait_cycles(H);
      dev_clk_low = 1'b0;
      if (i <= 10) bits[i-1] = ps2_dat_in;
      if (i == 11) dev_dat_low = 1'b0;
    end
  endtask

  // Wait for the transaction end and check it against the scoreboard.
  task automatic wait_end(input int limit);
    int n;
    logic [1:0] got, exp_end;
    n = 0;
    while (!done && !timeout && n < limit) begin
      @(negedge clk);
      n++;
    end
    got = done ? {1'b1, ack_ok} : (timeout ? 2'b01 : 2'b00);
    exp_end = end_q.pop_front();
    chk("end_kind", got, exp_end);
    chk("done_timeout_excl", done & timeout, 0);
    if (exp_end == 2'b01) begin
      chk("timeout_delay", cyc - rel_cyc, TO);
      chk("timeout_lines_free", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    end
    @(negedge clk);
    chk("pulse_width", {done, timeout}, 2'b00);
    chk("ready_after_end", cmd_ready, 1);
    chk("ack_held", ack_ok, (exp_end == 2'b11) ? 1 : 0);
  endtask

  initial begin
    logic [9:0] bits;
    logic [9:0] exp;

    // reset state; a command offered during reset must not start
    cmd_valid = 1'b1;
    cmd_data  = 8'h55;
    wait_cycles(3);
    chk("rst_enables", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {done, ack_ok, timeout}, 3'b000);
    chk("rst_state", state_dbg, 0);
    cmd_valid = 1'b0;
    reset = 1'b0;
    wait_cycles(3);
    chk("no_accept_in_reset", {busy, ps2_clk_oe}, 2'b00);

    // 0xED with ACK
    exp_q.push_back(frame_of(8'hED));
    end_q.push_back(2'b11);
    send(8'hED, 1'b0);
    dev_frame(11, 1'b1, bits);
    chk("frame_ED", bits, exp_q.pop_front());
    wait_end(200);

    // 0xF4 with ACK, parity 0
    exp_q.push_back(frame_of(8'hF4));
    end_q.push_back(2'b11);
    send(8'hF4, 1'b0);
    dev_frame(11, 1'b1, bits);
    chk("frame_F4", bits, exp_q.pop_front());
    wait_end(200);

    // 0x00, device does not ACK
    exp_q.push_back(frame_of(8'h00));
    end_q.push_back(2'b10);
    send(8'h00, 1'b0);
    dev_frame(11, 1'b0, bits);
    chk("frame_00", bits, exp_q.pop_front());
    wait_end(200);

    // device stops after edge 4 -> timeout
    exp_q.push_back(frame_of(8'hA5));
    end_q.push_back(2'b01);
    send(8'hA5, 1'b0);
    dev_frame(4, 1'b0, bits);
    exp = exp_q.pop_front();
    chk("frame_A5_part", bits[3:0], exp[3:0]);
    wait_end(TO + 200);

    // reset while inhibiting drops the clock enable at once
    wait_cycles(2);
    cmd_valid = 1'b1;
    cmd_data  = 8'h12;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_cycles(100);
    chk("inhibit_mid", ps2_clk_oe, 1);
    reset = 1'b1;
    #1;
    chk("rst_inhibit_clk_oe", ps2_clk_oe, 0);
    chk("rst_inhibit_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_cycles(2);

    // 0xFF interrupted by reset after edge 6
    exp_q.push_back(frame_of(8'hFF));
    send(8'hFF, 1'b0);
    dev_frame(6, 1'b0, bits);
    exp = exp_q.pop_front();
    chk("frame_FF_part", bits[5:0], exp[5:0]);
    reset = 1'b1;
    #1;
    chk("rst_frame_enables", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    chk("rst_frame_state", state_dbg, 0);
    wait_cycles(3);
    chk("rst_frame_pulses", {done, timeout, ack_ok}, 3'b000);
    reset = 1'b0;
    wait_cycles(3);

    // 0xF4 after reset, with a cmd_valid offered while busy
    exp_q.push_back(frame_of(8'hF4));
    end_q.push_back(2'b11);
    send(8'hF4, 1'b1);
    dev_frame(11, 1'b1, bits);
    chk("frame_F4_again", bits, exp_q.pop_front());
    wait_end(200);
    wait_cycles(5);
    chk("no_queued_cmd", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter that sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard over the same PS2_CLK/PS2_DAT pins used by the receive path. It sits beside the PS/2 receiver in the I/O controller and drives the open-drain lines through active-high pull-low enables. The top level wires each pin as "enable ? 0 : z". The block runs the full inhibit / request-to-send / shift / acknowledge sequence and reports completion, ACK status, or timeout.

## Interface
- INHIBIT_CYCLES, 5000: cycles the host holds PS2 clock low before request-to-send (100 µs at 50 MHz).
- START_CYCLES, 50: cycles both lines are held low before the clock is released.
- TIMEOUT_CYCLES, 1000000: maximum cycles from clock release to transaction end (20 ms).
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command byte offered.
- cmd_data  in  8  command byte.
- cmd_ready  out  1  high in IDLE; a byte is accepted when cmd_valid && cmd_ready.
- busy  out  1  high in every state except IDLE.
- ps2_clk_in  in  1  raw PS2_CLK pin value (asynchronous).
- ps2_dat_in  in  1  raw PS2_DAT pin value (asynchronous).
- ps2_clk_oe  out  1  1 pulls PS2_CLK low.
- ps2_dat_oe  out  1  1 pulls PS2_DAT low.
- done  out  1  one-cycle pulse at normal completion.
- ack_ok  out  1  valid with done; 1 if the device pulled data low in the ACK slot. Held until the next accept.
- timeout  out  1  one-cycle pulse when TIMEOUT_CYCLES expires.

## Operation
- Both pin inputs pass through 2-FF synchronizers. A falling edge is detected as previous synced clock = 1 and current synced clock = 0.
- On accept, the byte is latched, odd parity is computed (parity = ~^cmd_data), and the edge counter is cleared.
- States and transitions:
  - IDLE: both enables 0. Exits to INHIBIT on accept.
  - INHIBIT: clk_oe = 1, dat_oe = 0, for INHIBIT_CYCLES cycles. Then goes to START.
  - START: clk_oe = 1, dat_oe = 1 (start bit 0), for START_CYCLES cycles. Then goes to SHIFT.
  - SHIFT: clk_oe = 0; the timeout counter starts. On falling edges 1..8, drive data bit 0..7 (LSB first; dat_oe = ~bit). On edge 9, drive parity. On edge 10, set dat_oe = 0 (stop bit, line released). On edge 11, set ack_ok = ~synced data and go to WAIT_IDLE.
  - WAIT_IDLE: wait until synced clock = 1 and synced data = 1. Then pulse done and go to IDLE.
- Timeout: if the counter reaches TIMEOUT_CYCLES in SHIFT or WAIT_IDLE:
  - pulse timeout, force ack_ok = 0, release both lines, return to IDLE;
  - no done pulse is issued.
- Timeout has priority over an edge or the idle condition occurring in the same cycle.
- Falling edges seen in IDLE, INHIBIT, or START are ignored; the receive path owns them.
- cmd_valid is ignored while busy, and there is no queueing.

## Timing
- Reset values (asserted immediately, asynchronously):
  - ps2_clk_oe = 0, ps2_dat_oe = 0 (lines released mid-frame);
  - cmd_ready = 1, busy = 0, done = 0, ack_ok = 0, timeout = 0;
  - state = IDLE, all counters = 0.
- No command is accepted while reset is high.
- Accept at cycle T: clk_oe rises at T+1. dat_oe rises at T+1+INHIBIT_CYCLES. clk_oe falls at T+1+INHIBIT_CYCLES+START_CYCLES.
- Pin falling edge to dat_oe update: exactly 3 clk cycles (2 synchronizer stages plus one registered update). This is well inside the ~30 µs device low phase.
- The ACK sample uses the synced data value in the same cycle edge 11 is detected.
- done and timeout are registered, one cycle wide, and mutually exclusive. cmd_ready returns high in the cycle after done or timeout.
- Counter widths must hold their parameter values; 20 bits covers the defaults.

## Test plan
- Send 0xED with a device model that ACKs:
  - data bits sampled on device rising edges are 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - ACK low produces done = 1 for one cycle with ack_ok = 1.
- Send 0xF4 (parity 0):
  - clk_oe held exactly 5000 cycles, then both lines low exactly 50 cycles;
  - the device sees parity 0, and done pulses.
- Send 0x00 with a device model that does not ACK (data stays high in slot 11): parity 1 is seen, done pulses with ack_ok = 0.
- Device stops clocking after edge 4: timeout pulses exactly 1000000 cycles after clock release, both enables are 0, there is no done pulse, and cmd_ready = 1 the next cycle.
- Assert reset after edge 6 of a 0xFF send: both enables drop in the same cycle, with no done or timeout. After reset release a new 0xF4 completes normally. A cmd_valid presented during busy is not accepted.
